// File: rtl/one_to_eight_distributor.sv
// -----------------------------------------------------------------------------
// one_to_eight_distributor
//
// Registered 1-to-8 distributor. A word offered on the input handshake is
// steered into one of eight holding registers. The destination is either the
// explicit select or an internal round-robin pointer. Each holding register
// drains through its own handshake, so one stalled consumer only blocks words
// that are aimed at it.
//
// Handshake semantics (input side and every output side): a transfer happens
// on a rising clock edge where valid and ready are both high. The producer
// keeps valid high, with data and select stable, until that transfer happens.
// Ready never depends on the valid it is paired with.
//
// Ports:
//   i_clk                 clock, rising edge
//   i_rst                 asynchronous active-high reset
//   i_input               word to distribute
//   i_valid               i_input / i_sel are valid
//   o_ready               the word can be taken this cycle
//   i_sel                 destination index 0..7 (0 = o_output1), select mode
//   i_rr_mode             1 = destination from o_rr_ptr, 0 = from i_sel
//   o_output1..o_output8  holding register contents
//   o_valid               bit k = o_output(k+1) holds an undelivered word
//   i_ready               bit k = consumer k takes o_output(k+1) this cycle
//   o_rr_ptr              current round-robin pointer
// -----------------------------------------------------------------------------
module one_to_eight_distributor #(
   parameter int DATA_WIDTH = 256
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_input,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2:0]            i_sel,
   input  logic                  i_rr_mode,
   output logic [DATA_WIDTH-1:0] o_output1,
   output logic [DATA_WIDTH-1:0] o_output2,
   output logic [DATA_WIDTH-1:0] o_output3,
   output logic [DATA_WIDTH-1:0] o_output4,
   output logic [DATA_WIDTH-1:0] o_output5,
   output logic [DATA_WIDTH-1:0] o_output6,
   output logic [DATA_WIDTH-1:0] o_output7,
   output logic [DATA_WIDTH-1:0] o_output8,
   output logic [7:0]            o_valid,
   input  logic [7:0]            i_ready,
   output logic [2:0]            o_rr_ptr
);

   logic [DATA_WIDTH-1:0] hold_q [8];
   logic [7:0]            valid_q;
   logic [7:0]            valid_d;
   logic [2:0]            ptr_q;
   logic [2:0]            dest;
   logic                  accept;
   logic [7:0]            load_vec;

   // Destination, input ready and the per-output valid update.
   // A slot can take a new word when it is empty or is being drained in the
   // same cycle; this gives one word per cycle into an always-ready consumer.
   always_comb begin
      dest     = i_rr_mode ? ptr_q : i_sel;
      o_ready  = ~valid_q[dest] | i_ready[dest];
      accept   = i_valid & o_ready;
      load_vec = 8'h00;
      if (accept) begin
         load_vec[dest] = 1'b1;
      end
      // Drained slots clear unless reloaded in the same cycle; a ready on an
      // empty slot clears nothing that was set.
      valid_d  = (valid_q & ~i_ready) | load_vec;
   end

   // Valid flags and round-robin pointer. The pointer moves only on an
   // accepted word in round-robin mode, so it waits on a full slot rather
   // than skipping it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 8'h00;
         ptr_q   <= 3'd0;
      end else begin
         valid_q <= valid_d;
         if (accept && i_rr_mode) begin
            ptr_q <= ptr_q + 3'd1;
         end
      end
   end

   // Holding registers keep their contents after a drain; only a load
   // changes them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < 8; k++) begin
            hold_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (load_vec[k]) begin
               hold_q[k] <= i_input;
            end
         end
      end
   end

   assign o_valid   = valid_q;
   assign o_rr_ptr  = ptr_q;
   assign o_output1 = hold_q[0];
   assign o_output2 = hold_q[1];
   assign o_output3 = hold_q[2];
   assign o_output4 = hold_q[3];
   assign o_output5 = hold_q[4];
   assign o_output6 = hold_q[5];
   assign o_output7 = hold_q[6];
   assign o_output8 = hold_q[7];

endmodule

// File: doc/one_to_eight_distributor.md
Name: one_to_eight_distributor

Overview:
Registered 1-to-8 distributor for 256-bit words, the write-side counterpart of the 8-to-1 word selector. It accepts a word on a valid/ready input and steers it into one of eight per-output holding registers. The destination comes from an explicit select, or from an internal round-robin pointer. Each output drains independently through its own valid/ready handshake, so a stalled consumer does not block traffic bound for other outputs.

Parameters:
DATA_WIDTH, 256, width of every data word (input, holding registers, outputs)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset; asynchronous, active-high
i_input  input  DATA_WIDTH  word to distribute
i_valid  input  1  i_input/i_sel valid
o_ready  output  1  distributor can accept the word this cycle
i_sel  input  3  destination index 0..7 (0 = o_output1); ignored when i_rr_mode=1
i_rr_mode  input  1  1 = destination from internal pointer, 0 = from i_sel
o_output1..o_output8  output  DATA_WIDTH each  holding-register contents for outputs 1..8
o_valid  output  8  bit k = o_output(k+1) holds an undelivered word
i_ready  input  8  bit k = consumer k takes o_output(k+1) this cycle
o_rr_ptr  output  3  current round-robin pointer

Behaviour:
- Reset (async assert, sync release): o_valid=8'h00, all o_outputN=0, o_rr_ptr=0. Reset mid-transfer discards all buffered words; no partial state survives.
- dest = i_rr_mode ? o_rr_ptr : i_sel (combinational).
- o_ready = !o_valid[dest] | i_ready[dest]. Combinational from i_sel, i_rr_mode, o_rr_ptr, o_valid and i_ready. It does not depend on i_valid.
- Accept = i_valid & o_ready. On accept: o_output(dest+1) <= i_input; o_valid[dest] <= 1.
- Latency: a word accepted in cycle n is visible with o_valid set in cycle n+1.
- Drain: for each k, if o_valid[k] & i_ready[k] and no accept targets k this cycle, then o_valid[k] <= 0. Data register holds its value after drain (not cleared).
- Simultaneous drain and load on the same output: o_valid[k] stays 1 and the register takes the new word. This sustains 1 word/cycle to a single always-ready consumer.
- i_ready[k] with o_valid[k]=0 has no effect.
- Holding registers never overwrite an undelivered word. When the target is full and its consumer is not ready, o_ready=0 and the upstream word must be held stable (standard valid/ready: once i_valid is asserted it stays high with i_input/i_sel stable until accepted).
- Round-robin pointer: advances by 1 only on accept while i_rr_mode=1, wrapping 7 -> 0 (3-bit modulo). It never skips a full output; it waits on it (strict in-order rotation). Accepts in select mode do not move it. Toggling i_rr_mode does not reset it.
- Outputs 1..8 are fully independent. Drains on any set of outputs may occur in the same cycle as one accept.
- No X propagation: i_sel and i_input are don't-care when i_valid=0, and no state changes.

Test Plan:
1. Reset, then i_sel=3, i_input=256'hA5.., i_valid 1 cycle, i_ready=0 -> next cycle o_valid=8'h08, o_output4=A5..; others stay 0.
2. Output 4 full with i_ready[3]=0, new word with i_sel=3 -> o_ready=0 and the word stalls. Raise i_ready[3] -> same cycle o_ready=1; next cycle o_output4=new word, o_valid[3]=1.
3. i_rr_mode=1, i_ready=8'hFF, 10 back-to-back words 1..10 -> o_ready held 1. Words 1..8 land on outputs 1..8, 9 on output1, 10 on output2. o_rr_ptr ends at 2.
4. i_rr_mode=1, pointer at 5 with output6 full and i_ready[5]=0 -> o_ready=0 and o_rr_ptr stays 5, even though other outputs are empty.
5. Fill all 8 outputs in select mode, then i_ready=8'hFF for one cycle -> o_valid=8'h00 next cycle. Data registers retain their values.
6. Assert i_rst asynchronously mid-stream with o_valid=8'h5A and o_rr_ptr=6 -> o_valid=0, all outputs 0 and o_rr_ptr=0 immediately, before the next clock edge.
